// File: rtl/tinker_mem_responder.sv
// Sequential memory target for the Tinker core: fetch/load/store over valid/ready
// with a programmable access latency, bounds checking and an error response.
module tinker_mem_responder #(
  parameter int unsigned MEM_SIZE = 524288,
  parameter int unsigned LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;

  logic [7:0]    bytes [MEM_SIZE];

  logic [32:0]   end_addr;
  logic          in_range;
  logic          commit;
  logic          do_write;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // 33-bit end address so an access wrapping past 2^32 is out of range
  assign end_addr = {1'b0, addr_q} + ((op_q == OP_FETCH) ? 33'd4 : 33'd8);
  assign in_range = (end_addr <= 33'(MEM_SIZE));
  assign base     = addr_q[AW-1:0];
  assign commit   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign do_write = commit && in_range && (op_q == OP_STORE) && !reset;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[63-8*i -: 8] = bytes[base + AW'(i)];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (in_range && (op_q != OP_RSVD)) begin
            resp_err_d = 1'b0;
            case (op_q)
              OP_FETCH: resp_rdata_d = {32'b0, rd_word[63:32]};
              OP_LOAD:  resp_rdata_d = rd_word;
              default:  resp_rdata_d = '0;
            endcase
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Captured request fields are only consumed while BUSY, so they need no reset
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Storage survives reset and may be preloaded from outside, hence a plain always
  always @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 8; i++) begin
        bytes[base + AW'(i)] <= wdata_q[63-8*i -: 8];
      end
    end
  end

endmodule
